// File: rtl/mux_sel_arbiter.sv
// rtl/mux_sel_arbiter.sv - round-robin burst-limited 2:1 valid/ready arbiter with registered output
module mux_sel_arbiter #(
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [WIDTH-1:0] a_data,
  input  logic             b_valid,
  output logic             b_ready,
  input  logic [WIDTH-1:0] b_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             sel
);

  // Burst limit expressed in the width of the beat counter.
  localparam logic [3:0] MAX_CNT = 4'(MAX_BURST);

  // Source encodings match the sel output: 0 = A, 1 = B.
  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [3:0] cnt;
  logic [3:0] cnt_nxt;
  logic       last;
  logic       last_nxt;
  logic       grant;
  logic       load_en;
  logic       any_valid;
  logic       owner_granted;

  // The output register may be refilled when it is empty or being consumed.
  assign load_en   = !out_valid || out_ready;
  assign any_valid = a_valid || b_valid;

  // Grant choice: a lone requester always wins; under contention the owner
  // keeps the grant until its burst budget is spent, and from IDLE the source
  // that was not served last goes first.
  always_comb begin
    grant = SRC_A;
    if (a_valid && b_valid) begin
      case (state)
        OWN_A:   grant = (cnt < MAX_CNT) ? SRC_A : SRC_B;
        OWN_B:   grant = (cnt < MAX_CNT) ? SRC_B : SRC_A;
        default: grant = ~last;
      endcase
    end else if (b_valid) begin
      grant = SRC_B;
    end
  end

  // Ready is only offered to the granted source, so the two are exclusive.
  assign a_ready = load_en && a_valid && (grant == SRC_A);
  assign b_ready = load_en && b_valid && (grant == SRC_B);

  // True when the granted source is the one that currently owns the output.
  assign owner_granted = ((state == OWN_A) && (grant == SRC_A)) ||
                         ((state == OWN_B) && (grant == SRC_B));

  // Arbitration state register: owner, burst count and last-served source.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= 4'd0;
      last  <= SRC_B;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      last  <= last_nxt;
    end
  end

  // Next owner/count/last; nothing moves while the output is stalled.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    last_nxt  = last;
    if (load_en) begin
      if (!any_valid) begin
        state_nxt = IDLE;
        cnt_nxt   = 4'd0;
      end else begin
        last_nxt = grant;
        if (owner_granted) begin
          cnt_nxt = (cnt >= MAX_CNT) ? MAX_CNT : cnt + 4'd1;
        end else begin
          cnt_nxt   = 4'd1;
          state_nxt = (grant == SRC_B) ? OWN_B : OWN_A;
        end
      end
    end
  end

  // Output register: capture the granted beat, drain when nothing is offered,
  // hold everything while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      sel       <= SRC_A;
    end else if (load_en) begin
      if (any_valid) begin
        out_valid <= 1'b1;
        out_data  <= (grant == SRC_B) ? b_data : a_data;
        sel       <= grant;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// tb/tb_mux_sel_arbiter.sv - directed self-checking bench for mux_sel_arbiter
module tb_mux_sel_arbiter;

  logic       clk;
  logic       rst_n;
  logic       a_valid;
  logic       a_ready;
  logic [7:0] a_data;
  logic       b_valid;
  logic       b_ready;
  logic [7:0] b_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       sel;

  int checks;
  int errors;

  mux_sel_arbiter #(.WIDTH(8), .MAX_BURST(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a_valid   (a_valid),
    .a_ready   (a_ready),
    .a_data    (a_data),
    .b_valid   (b_valid),
    .b_ready   (b_ready),
    .b_data    (b_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .sel       (sel)
  );

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 ns after the next rising edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Let combinational readies settle after driving inputs.
  task automatic settle;
    #1;
  endtask

  task automatic do_reset;
    rst_n     = 1'b0;
    a_valid   = 1'b0;
    b_valid   = 1'b0;
    a_data    = 8'h00;
    b_data    = 8'h00;
    out_ready = 1'b1;
    tick;
    tick;
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    do_reset;
    rst_n = 1'b0;
    settle;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++;
    if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data got %h want 00", out_data); end
    checks++;
    if (sel !== 1'b0) begin errors++; $display("FAIL reset_sel got %b want 0", sel); end
    rst_n = 1'b1;
  endtask

  task automatic test_single_source;
    logic [7:0] v [3];
    v = '{8'h11, 8'h22, 8'h33};
    do_reset;
    a_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a_data = v[i];
      settle;
      checks++;
      if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
        errors++; $display("FAIL single_ready beat %0d got a=%b b=%b want a=1 b=0", i, a_ready, b_ready);
      end
      tick;
      checks++;
      if (out_valid !== 1'b1 || out_data !== v[i] || sel !== 1'b0) begin
        errors++; $display("FAIL single_out beat %0d got v=%b d=%h s=%b want v=1 d=%h s=0", i, out_valid, out_data, sel, v[i]);
      end
    end
    a_valid = 1'b0;
    settle;
    checks++;
    if (b_ready !== 1'b0) begin errors++; $display("FAIL single_b_ready got %b want 0", b_ready); end
    tick;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 8'h33) begin
      errors++; $display("FAIL single_drain got v=%b d=%h want v=0 d=33", out_valid, out_data);
    end
  endtask

  task automatic test_contention;
    logic es [12];
    logic [7:0] exp_d;
    int na;
    int nb;
    es = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    na = 0;
    nb = 0;
    do_reset;
    a_valid = 1'b1;
    b_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      a_data = 8'hA0 + 8'(na);
      b_data = 8'hB0 + 8'(nb);
      settle;
      checks++;
      if (a_ready !== !es[i] || b_ready !== es[i]) begin
        errors++; $display("FAIL contention_ready cycle %0d got a=%b b=%b want a=%b b=%b", i, a_ready, b_ready, !es[i], es[i]);
      end
      exp_d = es[i] ? b_data : a_data;
      tick;
      checks++;
      if (sel !== es[i] || out_data !== exp_d || out_valid !== 1'b1) begin
        errors++; $display("FAIL contention_out cycle %0d got s=%b d=%h want s=%b d=%h", i, sel, out_data, es[i], exp_d);
      end
      if (es[i]) nb++;
      else na++;
    end
    a_valid = 1'b0;
    b_valid = 1'b0;
  endtask

  task automatic test_backpressure;
    do_reset;
    a_valid = 1'b1;
    a_data  = 8'h40;
    settle;
    tick;
    out_ready = 1'b0;
    a_data    = 8'h41;
    b_valid   = 1'b1;
    b_data    = 8'hB9;
    for (int i = 0; i < 3; i++) begin
      settle;
      checks++;
      if (a_ready !== 1'b0 || b_ready !== 1'b0) begin
        errors++; $display("FAIL bp_ready cycle %0d got a=%b b=%b want 0 0", i, a_ready, b_ready);
      end
      tick;
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'h40 || sel !== 1'b0) begin
        errors++; $display("FAIL bp_hold cycle %0d got v=%b d=%h s=%b want v=1 d=40 s=0", i, out_valid, out_data, sel);
      end
    end
    out_ready = 1'b1;
    settle;
    checks++;
    if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
      errors++; $display("FAIL bp_release_ready got a=%b b=%b want a=1 b=0", a_ready, b_ready);
    end
    tick;
    checks++;
    if (out_data !== 8'h41 || sel !== 1'b0) begin
      errors++; $display("FAIL bp_release_out got d=%h s=%b want d=41 s=0", out_data, sel);
    end
    a_valid = 1'b0;
    b_valid = 1'b0;
  endtask

  task automatic test_valid_drop;
    do_reset;
    b_valid = 1'b1;
    b_data  = 8'hB1;
    settle;
    tick;
    b_data = 8'hB2;
    settle;
    tick;
    checks++;
    if (sel !== 1'b1 || out_data !== 8'hB2) begin
      errors++; $display("FAIL drop_setup got d=%h s=%b want d=b2 s=1", out_data, sel);
    end
    b_valid = 1'b0;
    a_valid = 1'b1;
    a_data  = 8'hA1;
    settle;
    checks++;
    if (a_ready !== 1'b1) begin errors++; $display("FAIL drop_a_ready got %b want 1", a_ready); end
    tick;
    checks++;
    if (sel !== 1'b0 || out_data !== 8'hA1) begin
      errors++; $display("FAIL drop_switch got d=%h s=%b want d=a1 s=0", out_data, sel);
    end
    b_valid = 1'b1;
    b_data  = 8'hB3;
    for (int k = 2; k <= 4; k++) begin
      a_data = 8'hA0 + 8'(k);
      settle;
      checks++;
      if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
        errors++; $display("FAIL drop_a_burst beat %0d got a=%b b=%b want a=1 b=0", k, a_ready, b_ready);
      end
      tick;
    end
    settle;
    checks++;
    if (a_ready !== 1'b0 || b_ready !== 1'b1) begin
      errors++; $display("FAIL drop_b_return_ready got a=%b b=%b want a=0 b=1", a_ready, b_ready);
    end
    tick;
    checks++;
    if (sel !== 1'b1 || out_data !== 8'hB3) begin
      errors++; $display("FAIL drop_b_return got d=%h s=%b want d=b3 s=1", out_data, sel);
    end
    a_valid = 1'b0;
    b_valid = 1'b0;
  endtask

  task automatic test_saturation;
    do_reset;
    a_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      a_data = 8'h50 + 8'(i);
      settle;
      tick;
    end
    checks++;
    if (out_data !== 8'h55 || sel !== 1'b0) begin
      errors++; $display("FAIL sat_owner got d=%h s=%b want d=55 s=0", out_data, sel);
    end
    b_valid = 1'b1;
    b_data  = 8'hBE;
    settle;
    checks++;
    if (b_ready !== 1'b1 || a_ready !== 1'b0) begin
      errors++; $display("FAIL sat_switch_ready got a=%b b=%b want a=0 b=1", a_ready, b_ready);
    end
    tick;
    checks++;
    if (sel !== 1'b1 || out_data !== 8'hBE) begin
      errors++; $display("FAIL sat_switch got d=%h s=%b want d=be s=1", out_data, sel);
    end
    a_valid = 1'b0;
    b_valid = 1'b0;
  endtask

  task automatic test_idle_gap;
    do_reset;
    b_valid = 1'b1;
    b_data  = 8'hB5;
    settle;
    tick;
    b_data = 8'hB6;
    settle;
    tick;
    b_valid = 1'b0;
    settle;
    tick;
    tick;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 8'hB6 || sel !== 1'b1) begin
      errors++; $display("FAIL idle_drain got v=%b d=%h s=%b want v=0 d=b6 s=1", out_valid, out_data, sel);
    end
    a_valid = 1'b1;
    b_valid = 1'b1;
    a_data  = 8'hA7;
    b_data  = 8'hB7;
    settle;
    checks++;
    if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
      errors++; $display("FAIL idle_ready got a=%b b=%b want a=1 b=0", a_ready, b_ready);
    end
    tick;
    checks++;
    if (sel !== 1'b0 || out_data !== 8'hA7) begin
      errors++; $display("FAIL idle_first got d=%h s=%b want d=a7 s=0", out_data, sel);
    end
    a_valid = 1'b0;
    b_valid = 1'b0;
  endtask

  task automatic test_async_reset;
    do_reset;
    b_valid = 1'b1;
    b_data  = 8'hC1;
    settle;
    tick;
    b_data = 8'hC2;
    settle;
    tick;
    checks++;
    if (out_valid !== 1'b1 || sel !== 1'b1 || out_data !== 8'hC2) begin
      errors++; $display("FAIL areset_setup got v=%b d=%h s=%b want v=1 d=c2 s=1", out_valid, out_data, sel);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || sel !== 1'b0 || out_data !== 8'h00) begin
      errors++; $display("FAIL areset_immediate got v=%b d=%h s=%b want v=0 d=00 s=0", out_valid, out_data, sel);
    end
    tick;
    rst_n   = 1'b1;
    a_valid = 1'b1;
    b_valid = 1'b1;
    a_data  = 8'hD1;
    b_data  = 8'hD2;
    settle;
    checks++;
    if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
      errors++; $display("FAIL areset_ready got a=%b b=%b want a=1 b=0", a_ready, b_ready);
    end
    tick;
    checks++;
    if (sel !== 1'b0 || out_data !== 8'hD1) begin
      errors++; $display("FAIL areset_first got d=%h s=%b want d=d1 s=0", out_data, sel);
    end
    a_valid = 1'b0;
    b_valid = 1'b0;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    a_valid   = 1'b0;
    b_valid   = 1'b0;
    a_data    = 8'h00;
    b_data    = 8'h00;
    out_ready = 1'b1;
    test_reset;
    test_single_source;
    test_contention;
    test_backpressure;
    test_valid_drop;
    test_saturation;
    test_idle_gap;
    test_async_reset;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux_sel_arbiter.md
Name: mux_sel_arbiter

Overview:
- Upstream stage for the team's 2:1 `mux` block.
- Arbitrates two valid/ready source channels (A, B) into one registered output channel.
- Drives `sel` (0 = A, 1 = B) so a downstream `mux` instance can steer side-band signals in step with `out_data`.
- Round-robin with a burst limit, so neither source can starve the other.

Parameters:
- WIDTH, 8, data width of each channel.
- MAX_BURST, 4, max consecutive beats granted to one source while the other is requesting (legal range 1..15).

Ports:
- clk        input   1      rising-edge clock
- rst_n      input   1      asynchronous active-low reset
- a_valid    input   1      source A has data
- a_ready    output  1      source A beat accepted this cycle
- a_data     input   WIDTH  source A data
- b_valid    input   1      source B has data
- b_ready    output  1      source B beat accepted this cycle
- b_data     input   WIDTH  source B data
- out_valid  output  1      out_data holds an unconsumed beat
- out_ready  input   1      consumer accepts out_data
- out_data   output  WIDTH  registered selected beat
- sel        output  1      source of current out_data (0 = A, 1 = B); registered with out_data

Behaviour:
- **Reset.** rst_n low acts asynchronously:
  - out_valid=0, out_data=0, sel=0, state=IDLE, cnt=0, last=B (so A wins the first contention).
- **Load enable.** load_en = !out_valid || out_ready.
- **Transfer rule.** A beat transfers on a rising clk edge when load_en=1 and the chosen source's valid=1.
- **Ready outputs.** a_ready = load_en && grant==A && a_valid; b_ready likewise for B. Both are combinational from valids, out_ready and state; never both 1 in one cycle.
- **Latency.** 1 cycle: the accepted beat appears on out_data/sel/out_valid the following cycle.
- **Output hold.** out_valid stays 1 and out_data/sel stay frozen until out_ready=1.
- **Output drain.** If load_en=1 and neither source is valid, out_valid goes to 0 on the next edge; out_data and sel are unchanged.
- **States.** IDLE, OWN_A, OWN_B. cnt (4 bits) counts consecutive beats granted to the current owner.
- **Grant decision** (evaluated only when load_en=1):
  - Neither valid: no transfer; state→IDLE, cnt→0; last keeps the last served source.
  - Only one valid: grant it.
  - Both valid, state OWN_X and cnt<MAX_BURST: grant X.
  - Both valid, state OWN_X and cnt>=MAX_BURST: grant the other source.
  - Both valid, state IDLE: grant the source != last.
- **State update on transfer.**
  - Granted source == current owner: cnt=min(cnt+1, MAX_BURST).
  - Otherwise: cnt=1, state=OWN_granted.
  - In all transfer cases: last=granted, sel=granted, out_data=granted data.
- **Saturation.** With only the owner valid, cnt saturates at MAX_BURST and the owner keeps the grant. When the other source then raises valid, it wins on the next transfer.
- **Valid drop.** If the owner drops valid while the other is valid, the switch happens immediately; cnt=1.
- **load_en=0.** No state, cnt or last change; both readies are 0.
- **Source data.** Sampled only at transfer; a source may change data while not ready.
- **Reset mid-burst.** Any in-flight out_data is dropped and out_valid falls immediately. Sources must re-present any beat not yet acked by ready.
- **Mid-burst data stability.** No combinational path from a_data/b_data to out_data.

Test Plan:
1. Single source:
   - Stimulus: only A valid, out_ready=1, a_data=0x11,0x22,0x33 on consecutive cycles.
   - Response: out_data 0x11,0x22,0x33 one cycle later; sel=0; out_valid=1 for 3 cycles then 0; b_ready=0 throughout.
2. Contention fairness:
   - Stimulus: MAX_BURST=4; A and B valid continuously from reset; out_ready=1; a_data=0xA0+n, b_data=0xB0+n.
   - Response: sel sequence 0,0,0,0,1,1,1,1,0,0,0,0; each channel's beats appear in order, no duplicates or losses.
3. Backpressure:
   - Stimulus: A streaming; out_ready=0 for 3 cycles while out_valid=1.
   - Response: out_data and sel held constant; a_ready=b_ready=0 for those cycles; the first beat after release is the next A beat, no loss.
4. Owner valid drop:
   - Stimulus: B owns with cnt=2; b_valid drops while a_valid=1.
   - Response: A granted the next cycle (sel=0, cnt=1); a later B return is granted after A reaches 4 beats, or immediately if A drops valid.
5. Idle gap fairness:
   - Stimulus: B burst of 2; both idle 2 cycles; then both valid in the same cycle.
   - Response: A granted first (last=B); sel=0.
6. Async reset mid-burst:
   - Stimulus: rst_n low between clock edges during a B burst.
   - Response: out_valid=0, sel=0, out_data=0 immediately without a clock; after release with both valid, A is granted first.
